hd_input_stage: RTL and testbench

- Multi-channel sample buffer directly upstream of the HD accelerator.
- Accepts preprocessed samples tagged with a channel index from the preprocessing front-end and stores them in one small FIFO per channel.
- Presents the head sample of the currently selected channel on the accelerator's idata interface.
- The accelerator's ucode sequencer consumes samples with ack_sample and advances channels round-robin with switch_channel.

---
 rtl/hd_input_stage.sv | 187 ++++++++++++++++++
 tb/tb_hd_input_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hd_input_stage.sv
// hd_input_stage: per-channel sample FIFOs feeding the HD accelerator idata port.
// Build option: define HD_INPUT_STAGE_DROP_OLDEST_EN to overwrite the oldest entry of a full channel.
package pkg_common;
  localparam int PREPROC_DATA_WIDTH = 8;
endpackage

module hd_input_stage #(
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_WIDTH   = pkg_common::PREPROC_DATA_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            sample_valid_i,
  output logic                            sample_ready_o,
  input  logic [$clog2(NUM_CHANNELS)-1:0] sample_ch_i,
  input  logic [DATA_WIDTH-1:0]           sample_i,
  output logic                            idata_valid_o,
  output logic [DATA_WIDTH-1:0]           idata_o,
  input  logic                            idata_ack_sample_i,
  input  logic                            idata_switch_channel_i,
  output logic [$clog2(NUM_CHANNELS)-1:0] cur_ch_o,
  output logic                            overflow_o
);

  localparam int CH_W  = $clog2(NUM_CHANNELS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [CH_W-1:0]  CH_ZERO  = {CH_W{1'b0}};
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);

  logic [DATA_WIDTH-1:0] mem_r    [NUM_CHANNELS][FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r [NUM_CHANNELS];
  logic [PTR_W-1:0]      wr_ptr_r [NUM_CHANNELS];
  logic [CNT_W-1:0]      count_r  [NUM_CHANNELS];
  logic [CH_W-1:0]       cur_ch_r;

  logic [PTR_W-1:0]      rd_ptr_nxt_s [NUM_CHANNELS];
  logic [PTR_W-1:0]      wr_ptr_nxt_s [NUM_CHANNELS];
  logic [CNT_W-1:0]      count_nxt_s  [NUM_CHANNELS];
  logic [CH_W-1:0]       cur_ch_nxt_s;

  logic [NUM_CHANNELS-1:0] full_s;
  logic [NUM_CHANNELS-1:0] empty_s;
  logic [NUM_CHANNELS-1:0] push_ch_s;
  logic [NUM_CHANNELS-1:0] pop_ch_s;
  logic [NUM_CHANNELS-1:0] ovw_ch_s;
  logic                    push_s;
  logic                    pop_s;

  // Per-channel occupancy flags
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      full_s[c]  = (count_r[c] == CNT_FULL);
      empty_s[c] = (count_r[c] == CNT_ZERO);
    end
  end

`ifdef HD_INPUT_STAGE_DROP_OLDEST_EN
  assign sample_ready_o = 1'b1;
`else
  logic ready_s;

  // Ready reflects only the addressed channel's fullness, never a same-cycle pop
  always_comb begin
    ready_s = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ready_s = ready_s | ((sample_ch_i == CH_W'(c)) & ~full_s[c]);
    end
  end

  assign sample_ready_o = ready_s;
`endif

  assign push_s = sample_valid_i & sample_ready_o;
  assign pop_s  = idata_ack_sample_i & idata_valid_o;

  // Route push/pop to channels; an overwrite is a push into a full channel that is not popping
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      push_ch_s[c] = push_s & (sample_ch_i == CH_W'(c));
      pop_ch_s[c]  = pop_s & (cur_ch_r == CH_W'(c));
`ifdef HD_INPUT_STAGE_DROP_OLDEST_EN
      ovw_ch_s[c]  = push_ch_s[c] & full_s[c] & ~pop_ch_s[c];
`else
      ovw_ch_s[c]  = 1'b0;
`endif
    end
  end

  // Next pointer/count state; flush dominates every other event
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rd_ptr_nxt_s[c] = rd_ptr_r[c];
      wr_ptr_nxt_s[c] = wr_ptr_r[c];
      count_nxt_s[c]  = count_r[c];
      if (flush_i) begin
        rd_ptr_nxt_s[c] = PTR_ZERO;
        wr_ptr_nxt_s[c] = PTR_ZERO;
        count_nxt_s[c]  = CNT_ZERO;
      end else begin
        if (push_ch_s[c]) begin
          wr_ptr_nxt_s[c] = wr_ptr_r[c] + PTR_W'(1);
        end else begin
          wr_ptr_nxt_s[c] = wr_ptr_r[c];
        end
        if (pop_ch_s[c] | ovw_ch_s[c]) begin
          rd_ptr_nxt_s[c] = rd_ptr_r[c] + PTR_W'(1);
        end else begin
          rd_ptr_nxt_s[c] = rd_ptr_r[c];
        end
        if (push_ch_s[c] & ~pop_ch_s[c] & ~ovw_ch_s[c]) begin
          count_nxt_s[c] = count_r[c] + CNT_W'(1);
        end else if (pop_ch_s[c] & ~push_ch_s[c]) begin
          count_nxt_s[c] = count_r[c] - CNT_W'(1);
        end else begin
          count_nxt_s[c] = count_r[c];
        end
      end
    end
  end

  // Channel pointer: the pop above uses the old channel, the switch lands next cycle
  always_comb begin
    cur_ch_nxt_s = cur_ch_r;
    if (flush_i) begin
      cur_ch_nxt_s = CH_ZERO;
    end else if (idata_switch_channel_i) begin
      cur_ch_nxt_s = (cur_ch_r == CH_LAST) ? CH_ZERO : cur_ch_r + CH_W'(1);
    end else begin
      cur_ch_nxt_s = cur_ch_r;
    end
  end

  // State and storage registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_ch_r <= CH_ZERO;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        rd_ptr_r[c] <= PTR_ZERO;
        wr_ptr_r[c] <= PTR_ZERO;
        count_r[c]  <= CNT_ZERO;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          mem_r[c][e] <= {DATA_WIDTH{1'b0}};
        end
      end
    end else begin
      cur_ch_r <= cur_ch_nxt_s;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        rd_ptr_r[c] <= rd_ptr_nxt_s[c];
        wr_ptr_r[c] <= wr_ptr_nxt_s[c];
        count_r[c]  <= count_nxt_s[c];
        if (!flush_i && push_ch_s[c]) begin
          mem_r[c][wr_ptr_r[c]] <= sample_i;
        end
      end
    end
  end

`ifdef HD_INPUT_STAGE_DROP_OLDEST_EN
  logic overflow_r;

  // Sticky overwrite indication, cleared only by flush or reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_r <= 1'b0;
    end else if (flush_i) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r | (|ovw_ch_s);
    end
  end

  assign overflow_o = overflow_r;
`else
  assign overflow_o = 1'b0;
`endif

  assign idata_valid_o = ~empty_s[cur_ch_r];
  assign idata_o       = mem_r[cur_ch_r][rd_ptr_r[cur_ch_r]];
  assign cur_ch_o      = cur_ch_r;

endmodule

// File: tb/tb_hd_input_stage.sv
// Scoreboard bench for hd_input_stage: queue-per-channel reference model, popped samples checked by a monitor.
module tb_hd_input_stage;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int CW    = 2;
`ifdef HD_INPUT_STAGE_DROP_OLDEST_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          sample_valid_i = 1'b0;
  logic          sample_ready_o;
  logic [CW-1:0] sample_ch_i = '0;
  logic [DW-1:0] sample_i = '0;
  logic          idata_valid_o;
  logic [DW-1:0] idata_o;
  logic          idata_ack_sample_i = 1'b0;
  logic          idata_switch_channel_i = 1'b0;
  logic [CW-1:0] cur_ch_o;
  logic          overflow_o;

  hd_input_stage #(.NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .sample_ch_i(sample_ch_i), .sample_i(sample_i),
    .idata_valid_o(idata_valid_o), .idata_o(idata_o),
    .idata_ack_sample_i(idata_ack_sample_i),
    .idata_switch_channel_i(idata_switch_channel_i),
    .cur_ch_o(cur_ch_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] mq [NCH][$];
  int            mcur = 0;
  bit            movf = 1'b0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted ack must present the oldest sample the model queued
  always @(negedge clk_i) begin
    if (rst_ni && !flush_i && idata_valid_o && idata_ack_sample_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got 0x%0h expected no pop at %0t", idata_o, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("pop_data", 32'(idata_o), 32'(mon_exp));
      end
    end
  end

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    mcur = 0;
    movf = 1'b0;
  endtask

  task automatic step(input bit v, input int ch, input int d, input bit ack, input bit sw, input bit fl);
    bit exp_rdy;
    bit do_pop;
    bit do_push;
    @(posedge clk_i);
    #2;
    sample_valid_i         = v;
    sample_ch_i            = CW'(ch);
    sample_i               = DW'(d);
    idata_ack_sample_i     = ack;
    idata_switch_channel_i = sw;
    flush_i                = fl;
    #1;
    exp_rdy = DROP || (mq[ch].size() < DEPTH);
    chk("sample_ready", 32'(sample_ready_o), 32'(exp_rdy));
    chk("idata_valid", 32'(idata_valid_o), 32'(mq[mcur].size() != 0));
    chk("cur_ch", 32'(cur_ch_o), 32'(mcur));
    chk("overflow", 32'(overflow_o), 32'(movf));
    if (fl) begin
      model_clear();
    end else begin
      do_push = v && exp_rdy;
      do_pop  = ack && (mq[mcur].size() != 0);
      if (do_pop) begin
        exp_q.push_back(mq[mcur][0]);
        void'(mq[mcur].pop_front());
      end
      if (do_push) begin
        if (mq[ch].size() == DEPTH) begin
          void'(mq[ch].pop_front());
          movf = 1'b1;
        end
        mq[ch].push_back(DW'(d));
      end
      if (sw) mcur = (mcur + 1) % NCH;
    end
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input int ch, input int d);
    step(1'b1, ch, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2;
    sample_valid_i = 1'b0; idata_ack_sample_i = 1'b0;
    idata_switch_channel_i = 1'b0; flush_i = 1'b0; sample_ch_i = '0;
    rst_ni = 1'b0;
    #1;
    chk("rst_idata_valid", 32'(idata_valid_o), 32'd0);
    chk("rst_idata", 32'(idata_o), 32'd0);
    chk("rst_cur_ch", 32'(cur_ch_o), 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);
    chk("rst_ready", 32'(sample_ready_o), 32'd1);
    chk("rst_pending", 32'(exp_q.size()), 32'd0);
    model_clear();
    exp_q.delete();
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    do_reset();
    // Basic push, 1-cycle latency and pops
    push(0, 8'h11); push(0, 8'h22); idle();
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    idle();
    // Fill ch2, refused fifth push, ready per addressed channel
    for (int i = 0; i < DEPTH; i++) push(2, 8'hC1 + i);
    push(2, 8'hEE); push(1, 8'h77); idle();
    // Switch sequence and ack+switch on ch1
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    push(1, 8'hA5); push(1, 8'h5A); idle();
    step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    // Push+pop on ch0 at count 2, then at full
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    push(0, 1); push(0, 2);
    step(1'b1, 0, 3, 1'b1, 1'b0, 1'b0);
    push(0, 4); push(0, 5);
    step(1'b1, 0, 6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    // Load all, flush with push/ack/switch, confirm everything empty
    for (int c = 0; c < NCH; c++) begin push(c, 16 * c + 1); push(c, 16 * c + 2); end
    step(1'b1, 1, 8'h99, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < NCH; c++) step(1'b0, c, 0, 1'b1, 1'b1, 1'b0);
    // Overfill ch0 with 1..5, drain the head, flush
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) push(0, i);
    idle();
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle();
    // Randomized traffic, a mid-operation reset, more traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, NCH - 1), $urandom_range(0, 255),
           $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2, $urandom_range(0, 49) == 0);
    do_reset();
    idle();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 5, $urandom_range(0, NCH - 1), $urandom_range(0, 255),
           $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0);
    idle();
    idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
